game_sequencer: RTL and testbench
=================================

Name:
game_sequencer

Overview:
- Top-level game flow controller for the typing game.
- Sequences the per-keystroke counting datapath through its four phases: SELECT, COUNTDOWN, INGAME and FINISH.
- Generates the `state`, `mode` and `value` configuration that datapath consumes, and runs the pre-game countdown.
- Runs on the slow tick clock `clk_div` (10 Hz); takes debounced button levels and the datapath's `finish` flag.

Parameters:
- COUNT_TICKS, 10, clk_div cycles per countdown second.
- COUNT_SECS, 3, countdown length in seconds (1..3).
- TIME_MIN, 15, minimum/default time-mode limit in seconds.
- TIME_MAX, 60, maximum time-mode limit.
- TIME_STEP, 15, time-mode adjust step.
- WORD_MIN, 10, minimum/default word-mode target count.
- WORD_MAX, 50, maximum word-mode target.
- WORD_STEP, 10, word-mode adjust step.
- Legal settings: all MAX ≤ 127; (MAX−MIN) is a multiple of STEP.

Ports:
- clk_div  input  1  slow tick clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- btn_start  input  1  debounced start/confirm button level, synchronous to clk_div.
- btn_mode  input  1  debounced mode-toggle button level.
- btn_up  input  1  debounced increment button level.
- btn_down  input  1  debounced decrement button level.
- finish  input  1  datapath game-over flag; level, held high while the end condition holds in INGAME.
- state  output  2  0=SELECT, 1=COUNTDOWN, 2=INGAME, 3=FINISH.
- mode  output  1  0=time mode, 1=word-count mode.
- value  output  7  time limit (s) or word target, per mode.
- cd_digit  output  2  countdown seconds remaining while in COUNTDOWN; 0 otherwise.
- busy  output  1  high in COUNTDOWN or INGAME.

Behaviour:
- Reset values:
  - state=SELECT, mode=0, value=TIME_MIN, cd_digit=0, busy=0.
  - Tick counter=0, second counter=0.
  - Button history registers=1, so a button held through reset produces no press until released.
- Press detection: press_x = btn_x & ~btn_x_q, with btn_x_q registered each cycle. A press lasts exactly one cycle; a held button yields one press.
- All outputs are registered. State and outputs update one clk_div edge after the qualifying press or condition.
- SELECT, press priority is start > mode > up/down:
  - start press -> COUNTDOWN; tick=0; sec=COUNT_SECS.
  - mode press -> toggle mode; value loads the new mode's MIN.
  - up press alone -> value += STEP, saturating at MAX. At MAX, value holds.
  - down press alone -> value −= STEP, saturating at MIN. At MIN, value holds.
  - up and down pressed in the same cycle -> no change.
  - Arithmetic is done in 8 bits before saturation, so no 7-bit wrap.
- COUNTDOWN:
  - Each cycle, tick increments.
  - When tick==COUNT_TICKS−1: tick←0 and sec decrements.
  - When sec==1 and tick==COUNT_TICKS−1: go to INGAME.
  - Total dwell is exactly COUNT_SECS*COUNT_TICKS cycles.
  - cd_digit=sec throughout (3,2,1 for the default settings).
  - mode, up and down are ignored. start is ignored unless GAME_ABORT_EN is defined.
- INGAME:
  - finish sampled high -> FINISH on the next edge.
  - All buttons are ignored, except start when GAME_ABORT_EN is defined.
  - mode and value are frozen.
- FINISH:
  - start press -> SELECT; mode and value are retained for a rematch.
  - Other buttons are ignored.
  - finish is ignored, since the datapath drops it outside INGAME.
- mode and value change only in SELECT. They are stable for the entire COUNTDOWN, INGAME and FINISH span.
- State encoding 0..3 is fully used; no illegal states exist.
- Reset mid-game returns to the reset values immediately (asynchronous).

Optional Feature:
- Macro: GAME_ABORT_EN.
- Defined:
  - A start press in COUNTDOWN or INGAME returns to SELECT on the next edge.
  - tick, sec and cd_digit are cleared; mode and value are retained.
  - In INGAME the abort takes priority over a simultaneous finish.
- Undefined: start is ignored in COUNTDOWN and INGAME. The only exits are the countdown expiring and finish.

Test Plan:
- Reset with btn_start held high, then held for 5 cycles -> state stays 0. Release and press -> state=1 one edge after the press.
- SELECT, mode=0: press up 4 times -> value 30, 45, 60, 60. Press down 4 times -> 45, 30, 15, 15. up+down in the same cycle -> value unchanged.
- Press mode in SELECT -> mode=1, value=10. Press up 5 times -> 50 (saturated). Press mode again -> mode=0, value=15.
- Start press in SELECT (defaults):
  - cd_digit reads 3 for 10 cycles, then 2 for 10, then 1 for 10.
  - state=2 exactly 30 cycles after entering COUNTDOWN; busy=1 throughout.
- In INGAME:
  - Toggle up/down/mode -> mode and value unchanged.
  - Assert finish -> state=3 next edge, busy=0.
  - Start press -> state=0 with value preserved.
- With GAME_ABORT_EN: start press at countdown cycle 12 -> state=0, cd_digit=0. Start press in INGAME together with finish=1 -> state=0, not 3. Without the macro, the same presses are ignored.

Source files
------------

// File: rtl/game_sequencer.sv
// Typing-game flow controller: SELECT -> COUNTDOWN -> INGAME -> FINISH, plus mode/value setup.
// Optional macro GAME_ABORT_EN: a start press aborts COUNTDOWN/INGAME back to SELECT.
module game_sequencer #(
  parameter int unsigned COUNT_TICKS = 10,
  parameter int unsigned COUNT_SECS  = 3,
  parameter int unsigned TIME_MIN    = 15,
  parameter int unsigned TIME_MAX    = 60,
  parameter int unsigned TIME_STEP   = 15,
  parameter int unsigned WORD_MIN    = 10,
  parameter int unsigned WORD_MAX    = 50,
  parameter int unsigned WORD_STEP   = 10
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       finish,
  output logic [1:0] state,
  output logic       mode,
  output logic [6:0] value,
  output logic [1:0] cd_digit,
  output logic       busy
);

  localparam int unsigned TICK_W = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(COUNT_TICKS - 1);
  localparam logic [1:0] SECS_INIT = 2'(COUNT_SECS);
  localparam logic [7:0] T_MIN  = 8'(TIME_MIN);
  localparam logic [7:0] T_MAX  = 8'(TIME_MAX);
  localparam logic [7:0] T_STEP = 8'(TIME_STEP);
  localparam logic [7:0] W_MIN  = 8'(WORD_MIN);
  localparam logic [7:0] W_MAX  = 8'(WORD_MAX);
  localparam logic [7:0] W_STEP = 8'(WORD_STEP);

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_INGAME    = 2'd2,
    ST_FINISH    = 2'd3
  } state_t;

  state_t            cur;
  logic [TICK_W-1:0] tick;
  logic [1:0]        sec;
  logic              start_q, mode_q, up_q, down_q;

  logic       press_start, press_mode, press_up, press_down;
  logic       abort_c;
  logic [7:0] v_min, v_max, v_step;
  logic [7:0] sum8, diff8, floor8;
  logic [6:0] inc_value, dec_value;

  assign state = cur;

  // Rising-edge detect; history regs reset high so a button held through reset is not a press
  assign press_start = btn_start & ~start_q;
  assign press_mode  = btn_mode  & ~mode_q;
  assign press_up    = btn_up    & ~up_q;
  assign press_down  = btn_down  & ~down_q;

`ifdef GAME_ABORT_EN
  assign abort_c = press_start;
`else
  assign abort_c = 1'b0;
`endif

  // Saturating adjust, computed in 8 bits so nothing wraps at the 7-bit boundary
  always_comb begin
    v_min     = mode ? W_MIN  : T_MIN;
    v_max     = mode ? W_MAX  : T_MAX;
    v_step    = mode ? W_STEP : T_STEP;
    sum8      = {1'b0, value} + v_step;
    diff8     = {1'b0, value} - v_step;
    floor8    = v_min + v_step;
    inc_value = value;
    dec_value = value;
    if (sum8 > v_max) inc_value = v_max[6:0];
    else              inc_value = sum8[6:0];
    if ({1'b0, value} < floor8) dec_value = v_min[6:0];
    else                        dec_value = diff8[6:0];
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      cur      <= ST_SELECT;
      mode     <= 1'b0;
      value    <= T_MIN[6:0];
      cd_digit <= 2'd0;
      busy     <= 1'b0;
      tick     <= '0;
      sec      <= 2'd0;
      start_q  <= 1'b1;
      mode_q   <= 1'b1;
      up_q     <= 1'b1;
      down_q   <= 1'b1;
    end else begin
      start_q <= btn_start;
      mode_q  <= btn_mode;
      up_q    <= btn_up;
      down_q  <= btn_down;

      case (cur)
        ST_SELECT: begin
          if (press_start) begin
            cur      <= ST_COUNTDOWN;
            tick     <= '0;
            sec      <= SECS_INIT;
            cd_digit <= SECS_INIT;
            busy     <= 1'b1;
          end else if (press_mode) begin
            mode  <= ~mode;
            value <= mode ? T_MIN[6:0] : W_MIN[6:0];
          end else if (press_up && !press_down) begin
            value <= inc_value;
          end else if (press_down && !press_up) begin
            value <= dec_value;
          end
        end

        ST_COUNTDOWN: begin
          if (abort_c) begin
            cur      <= ST_SELECT;
            tick     <= '0;
            sec      <= 2'd0;
            cd_digit <= 2'd0;
            busy     <= 1'b0;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            if (sec == 2'd1) begin
              cur      <= ST_INGAME;
              sec      <= 2'd0;
              cd_digit <= 2'd0;
            end else begin
              sec      <= sec - 2'd1;
              cd_digit <= sec - 2'd1;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        ST_INGAME: begin
          // Abort outranks a simultaneous finish
          if (abort_c) begin
            cur  <= ST_SELECT;
            busy <= 1'b0;
          end else if (finish) begin
            cur  <= ST_FINISH;
            busy <= 1'b0;
          end
        end

        ST_FINISH: begin
          if (press_start) cur <= ST_SELECT;
        end

        default: cur <= ST_SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a per-cycle behavioural model and literal spot checks.
module tb_game_sequencer;

  localparam int TICKS = 10;
  localparam int SECS  = 3;
  localparam int TMIN = 15, TMAX = 60, TSTEP = 15;
  localparam int WMIN = 10, WMAX = 50, WSTEP = 10;
`ifdef GAME_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk_div = 1'b0;
  logic       rst, btn_start, btn_mode, btn_up, btn_down, finish;
  logic [1:0] state;
  logic       mode;
  logic [6:0] value;
  logic [1:0] cd_digit;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Model: phase, settings, and cycles spent since the countdown began
  int   m_phase, m_value, m_elapsed;
  bit   m_mode;
  bit [3:0] m_prev;

  game_sequencer dut (
    .clk_div  (clk_div),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .finish   (finish),
    .state    (state),
    .mode     (mode),
    .value    (value),
    .cd_digit (cd_digit),
    .busy     (busy)
  );

  always #5 clk_div = ~clk_div;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit ps_s, ps_m, ps_u, ps_d;
    if (rst) begin
      m_phase = 0; m_mode = 1'b0; m_value = TMIN; m_elapsed = 0; m_prev = 4'hF;
      return;
    end
    ps_s = btn_start && !m_prev[3];
    ps_m = btn_mode  && !m_prev[2];
    ps_u = btn_up    && !m_prev[1];
    ps_d = btn_down  && !m_prev[0];
    case (m_phase)
      0: begin
        if (ps_s) begin
          m_phase = 1; m_elapsed = 0;
        end else if (ps_m) begin
          m_mode  = !m_mode;
          m_value = m_mode ? WMIN : TMIN;
        end else if (ps_u != ps_d) begin
          int lo, hi, st;
          lo = m_mode ? WMIN : TMIN;
          hi = m_mode ? WMAX : TMAX;
          st = m_mode ? WSTEP : TSTEP;
          m_value = ps_u ? m_value + st : m_value - st;
          if (m_value > hi) m_value = hi;
          if (m_value < lo) m_value = lo;
        end
      end
      1: begin
        if (ABORT && ps_s) m_phase = 0;
        else begin
          m_elapsed++;
          if (m_elapsed == SECS * TICKS) m_phase = 2;
        end
      end
      2: begin
        if (ABORT && ps_s) m_phase = 0;
        else if (finish)   m_phase = 3;
      end
      default: if (ps_s) m_phase = 0;
    endcase
    m_prev = {btn_start, btn_mode, btn_up, btn_down};
  endtask

  // One clock: advance model on the edge, compare just after it, return on the falling edge
  task automatic step();
    int exp_cd;
    @(posedge clk_div);
    model_update();
    #1;
    exp_cd = (m_phase == 1) ? SECS - m_elapsed / TICKS : 0;
    check("state",    int'(state),    m_phase);
    check("mode",     int'(mode),     int'(m_mode));
    check("value",    int'(value),    m_value);
    check("cd_digit", int'(cd_digit), exp_cd);
    check("busy",     int'(busy),     (m_phase == 1 || m_phase == 2) ? 1 : 0);
    @(negedge clk_div);
  endtask

  // b = {start, mode, up, down}: hold one cycle, then release one cycle
  task automatic press(input logic [3:0] b);
    {btn_start, btn_mode, btn_up, btn_down} = b;
    step();
    {btn_start, btn_mode, btn_up, btn_down} = 4'b0000;
    step();
  endtask

  initial begin
    rst = 1'b1; btn_start = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; finish = 1'b0;
    step(); step();
    check("rst_state", int'(state), 0);
    check("rst_value", int'(value), 15);
    check("rst_busy",  int'(busy),  0);
    rst = 1'b0;

    // Start held through reset gives no press
    repeat (5) step();
    check("held_start_state", int'(state), 0);
    btn_start = 1'b0;
    step();

    // Game 1: countdown timing
    btn_start = 1'b1;
    step();
    check("enter_cd_state", int'(state), 1);
    check("enter_cd_digit", int'(cd_digit), 3);
    btn_start = 1'b0;
    for (int i = 1; i < 30; i++) begin
      step();
      if (i == 9)  check("cd_last3", int'(cd_digit), 3);
      if (i == 10) check("cd_first2", int'(cd_digit), 2);
      if (i == 29) begin
        check("cd_last1", int'(cd_digit), 1);
        check("cd_still", int'(state), 1);
      end
    end
    step();
    check("ingame_at30", int'(state), 2);
    check("ingame_busy", int'(busy), 1);

    // INGAME ignores setup buttons
    press(4'b0100); press(4'b0010); press(4'b0001);
    check("ingame_mode",  int'(mode),  0);
    check("ingame_value", int'(value), 15);

    finish = 1'b1;
    step();
    check("finish_state", int'(state), 3);
    check("finish_busy",  int'(busy),  0);
    step(); step();
    finish = 1'b0;
    press(4'b1000);
    check("rematch_state", int'(state), 0);
    check("rematch_value", int'(value), 15);

    // SELECT value adjust, time mode
    press(4'b0010); check("up1", int'(value), 30);
    press(4'b0010); check("up2", int'(value), 45);
    press(4'b0010); check("up3", int'(value), 60);
    press(4'b0010); check("up4_sat", int'(value), 60);
    press(4'b0001); check("dn1", int'(value), 45);
    press(4'b0001); check("dn2", int'(value), 30);
    press(4'b0011); check("updn_same", int'(value), 30);
    press(4'b0001); check("dn3", int'(value), 15);
    press(4'b0001); check("dn4_sat", int'(value), 15);

    // Word mode
    press(4'b0100);
    check("mode_word", int'(mode), 1);
    check("word_min",  int'(value), 10);
    repeat (5) press(4'b0010);
    check("word_sat", int'(value), 50);
    press(4'b0100);
    check("mode_time", int'(mode), 0);
    check("time_min",  int'(value), 15);
    press(4'b0100);
    press(4'b0010);
    check("word_20", int'(value), 20);

    // Game 2: start press in countdown, then start+finish in INGAME
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    repeat (11) step();
    press(4'b1000);
    check("cd_abort_state", int'(state), ABORT ? 0 : 1);
    check("cd_abort_digit", int'(cd_digit), ABORT ? 0 : 2);
    if (m_phase == 0) press(4'b1000);
    for (int i = 0; i < 40 && m_phase != 2; i++) step();
    check("reach_ingame", int'(state), 2);
    finish = 1'b1; btn_start = 1'b1;
    step();
    check("abort_vs_finish", int'(state), ABORT ? 0 : 3);
    btn_start = 1'b0;
    step();
    finish = 1'b0;
    if (m_phase == 3) press(4'b1000);
    check("end_state", int'(state), 0);
    check("end_mode",  int'(mode),  1);
    check("end_value", int'(value), 20);

    // Asynchronous reset mid-game
    press(4'b1000);
    repeat (3) step();
    #2 rst = 1'b1;
    #1 check("async_rst_state", int'(state), 0);
    check("async_rst_value", int'(value), 15);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
